// File: rtl/mealey_overlap_pkg.sv
// Shared constants and types for the overlapping Mealy sequence detector.
// The state encoding is the number of leading pattern bits currently matched.
package mealey_overlap_pkg;

  localparam int                 SEQ_LEN_DEF = 4;
  localparam logic [SEQ_LEN_DEF-1:0] PATTERN_DEF = 4'b1011;

  // State width for a given pattern length; never narrower than one bit.
  function automatic int state_w(input int seq_len);
    return (seq_len > 1) ? $clog2(seq_len) : 1;
  endfunction

  localparam int STATE_W_DEF = state_w(SEQ_LEN_DEF);

  typedef logic [STATE_W_DEF-1:0] state_t;

endpackage

// File: rtl/mealey_overlap_if.sv
// Serial-in / detect-out bundle; the stimulus side drives a and watches y.
interface mealey_overlap_if;
  logic a;
  logic y;

  modport master (output a, input  y);
  modport slave  (input  a, output y);
endinterface

// File: rtl/mealey_overlap_next.sv
// Next-state / match logic: a constant KMP transition table built from
// PATTERN at elaboration, indexed by the current state and input bit.
module mealey_overlap_next #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 SW      = 2
) (
  input  logic [SW-1:0] state_i,
  input  logic          a_i,
  output logic [SW-1:0] next_o,
  output logic          match_o
);

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic bit pat_bit(input int i);
    logic [31:0] sh;
    sh = 32'(PATTERN) >> (SEQ_LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest proper prefix of PATTERN that is a suffix of (prefix_k, b).
  function automatic int kmp_next(input int k, input bit b);
    int best;
    int idx;
    bit ok;
    bit sb;
    best = 0;
    for (int j = 1; j < SEQ_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          idx = k + 1 - j + t;
          sb  = (idx == k) ? b : pat_bit(idx);
          if (sb != pat_bit(t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt0 [2**SW];
  logic [SW-1:0] nxt1 [2**SW];

  // Encodings at or beyond SEQ_LEN are unreachable and fall back to S0.
  for (genvar k = 0; k < 2**SW; k++) begin : g_tab
    if (k < SEQ_LEN) begin : g_live
      localparam int N0 = kmp_next(k, 1'b0);
      localparam int N1 = kmp_next(k, 1'b1);
      assign nxt0[k] = SW'(N0);
      assign nxt1[k] = SW'(N1);
    end else begin : g_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  always_comb begin
    next_o  = a_i ? nxt1[state_i] : nxt0[state_i];
    match_o = (state_i == SW'(SEQ_LEN - 1)) && (a_i == PATTERN[0]);
  end

endmodule

// File: rtl/mealey_overlap.sv
// Overlapping Mealy detector for a serial bit stream: y flags the final bit
// of PATTERN in the same cycle it arrives; synchronous active-high reset.
module mealey_overlap
  import mealey_overlap_pkg::*;
#(
  parameter int                 SEQ_LEN = SEQ_LEN_DEF,
  parameter logic [SEQ_LEN-1:0] PATTERN = SEQ_LEN'(PATTERN_DEF)
) (
  input  logic a,
  input  logic res,
  input  logic clk,
  output logic y
);

  localparam int SW = state_w(SEQ_LEN);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] nxt_state;
  logic          match;

  mealey_overlap_next #(
    .SEQ_LEN (SEQ_LEN),
    .PATTERN (PATTERN),
    .SW      (SW)
  ) u_next (
    .state_i (state_q),
    .a_i     (a),
    .next_o  (nxt_state),
    .match_o (match)
  );

  always_comb begin
    state_d = nxt_state;
  end

  always_ff @(posedge clk) begin
    if (res) state_q <= '0;
    else     state_q <= state_d;
  end

  // Mealy output: live on a, forced low while reset is held.
  always_comb begin
    y = match & ~res;
  end

endmodule

// File: tb/tb_mealey_overlap.sv
// Bench for mealey_overlap: directed streams with literal expectations, plus
// a history-based reference that rechecks both configurations every cycle.
module tb_mealey_overlap;

  logic clk;
  logic res;
  logic y3;

  mealey_overlap_if bus ();

  mealey_overlap dut (
    .a   (bus.a),
    .res (res),
    .clk (clk),
    .y   (bus.y)
  );

  mealey_overlap #(.SEQ_LEN(3), .PATTERN(3'b111)) dut3 (
    .a   (bus.a),
    .res (res),
    .clk (clk),
    .y   (y3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: y=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bits received since the last reset, newest in bit 0.
  logic [31:0] hist = '0;
  int          cnt  = 0;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    if (res) begin
      hist   <= '0;
      cnt    <= 0;
      mvalid <= 1'b1;
    end else begin
      hist <= {hist[30:0], bus.a};
      cnt  <= cnt + 1;
    end
  end

  // Detect iff the last L bits received, including the live one, equal pat.
  function automatic bit mdl(input int len, input logic [31:0] pat);
    logic [31:0] full;
    logic [31:0] mask;
    full = {hist[30:0], bus.a};
    mask = (32'd1 << len) - 32'd1;
    return !res && (cnt + 1 >= len) && ((full & mask) == pat);
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_1011", bus.y, mdl(4, 32'hB));
      chk("model_111",  y3,    mdl(3, 32'h7));
    end
  end

  task automatic step(input logic ai, input logic ri, input logic e4,
                      input bit use3, input logic e3, input string nm);
    bus.a = ai;
    res   = ri;
    @(negedge clk);
    #1;
    chk(nm, bus.y, e4);
    if (use3) chk({nm, "_len3"}, y3, e3);
    @(posedge clk);
    #1;
  endtask

  // Apply n bits (MSB first) after a one-edge reset; ev/e3v list expected y.
  task automatic run(input string nm, input int n, input logic [31:0] av,
                     input logic [31:0] ev, input bit use3, input logic [31:0] e3v);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {nm, "_rst"});
    for (int i = n - 1; i >= 0; i--)
      step(av[i], 1'b0, ev[i], use3, e3v[i], $sformatf("%s_bit%0d", nm, n - i));
  endtask

  initial begin
    bus.a = 1'b0;
    res   = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "reset_hold");

    // 1011 then 0,1,1: second pulse proves the state after a hit is S1.
    run("basic",    7,  32'b1011011,      32'b0001001,      1'b0, '0);
    run("stream12", 12, 32'b101110111011, 32'b000100010001, 1'b0, '0);
    run("overlap",  7,  32'b1011011,      32'b0001001,      1'b0, '0);
    run("fail_a",   5,  32'b11011,        32'b00001,        1'b0, '0);
    run("fail_b",   7,  32'b1001011,      32'b0000001,      1'b0, '0);

    // Reset lands while sitting in the last-bit state with a=1.
    run("midrst",   3,  32'b101,          32'b000,          1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "midrst_res");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_a1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_a0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_a1b");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "midrst_full");

    run("sweep111", 5,  32'b11111,        32'b00000,        1'b1, 32'b00111);

    // Mid-cycle change of a in the final state must drop y immediately.
    run("comb", 3, 32'b101, 32'b000, 1'b0, '0);
    bus.a = 1'b1;
    #2;
    chk("comb_hi", bus.y, 1'b1);
    bus.a = 1'b0;
    #1;
    chk("comb_lo", bus.y, 1'b0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
